// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch stage in front of the single-cycle datapath.
//
// Owns the program counter, issues one sequential instruction-memory read per
// cycle whenever the buffer has room, and queues each returned {pc, insn} pair
// in a DEPTH-entry FIFO that feeds the datapath. A taken branch/jump from
// execute (redirect) flushes the FIFO and restarts fetch at the target.
//
// Optional build macro: IFETCH_PERF_CNT_EN adds the perf_fetched and
// perf_flushes counter outputs. With it undefined, those ports and their logic
// are absent and all other behaviour is identical.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-high reset
//   imem_req       out  read request this cycle (0 while reset is high)
//   imem_addr      out  read address, word aligned
//   imem_rdata     in   read data, valid with imem_rvalid
//   imem_rvalid    in   response strobe, exactly 1 cycle after imem_req
//   redirect_valid in   taken branch/jump from execute
//   redirect_pc    in   redirect target (bits [1:0] ignored)
//   inst_valid     out  FIFO head valid
//   inst_ready     in   datapath accepts the head
//   inst_pc        out  head PC
//   inst_data      out  head instruction word
//   perf_fetched   out  (macro only) pushes into the FIFO, wraps at 2^32
//   perf_flushes   out  (macro only) redirect cycles, wraps at 2^32
//
// Handshake: a transfer on inst_* happens in every cycle where inst_valid and
// inst_ready are both 1 at the rising edge; inst_valid never depends on
// inst_ready, and the head stays stable until it is accepted or flushed.
module ifetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_rvalid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [31:0]     inst_data
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q;
  logic [XLEN-1:0] issued_addr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     data_mem_q [DEPTH];

  logic [XLEN-1:0] redirect_aligned;
  logic [CW:0]     credit_used;
  logic            push;
  logic            pop;

  // Low target bits are defined as don't-care.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

  // Credit counts both stored entries and the response still on its way.
  // A pop in this cycle earns no credit, which keeps the check off the
  // inst_ready path and makes overflow impossible. Redirect bypasses the
  // check because it empties the FIFO at the same edge.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign imem_req    = !reset && (redirect_valid || (credit_used < DEPTH_C));
  assign imem_addr   = redirect_valid ? redirect_aligned : pc_q;

  // Responses without a matching request, or landing in a redirect cycle,
  // belong to a stale or nonexistent fetch and are dropped.
  assign push = imem_rvalid && inflight_q && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign inst_valid = (count_q != '0);
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_data  = data_mem_q[rd_ptr_q];

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (imem_req) begin
      pc_d = imem_addr + XLEN'(4);
    end
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      issued_addr_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= imem_req;
      if (imem_req) issued_addr_q <= imem_addr;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is reset so the head outputs read 0 while empty after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= issued_addr_q;
      data_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushes_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (push)           perf_fetched_q <= perf_fetched_q + 32'd1;
      if (redirect_valid) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Testbench for ifetch_queue: instruction memory model returning word = addr,
// expected {pc, insn} stream kept in a queue and compared on each handshake.
module tb_ifetch_queue;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_rvalid;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [31:0]     inst_data;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_flushes;
`endif

  ifetch_queue #(.XLEN(XLEN), .DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [XLEN+31:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  logic             inject_rv;
  logic             mem_r;
  logic [XLEN-1:0]  mem_a;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected consumed stream after a (re)start: sequential words from start.
  task automatic sb_restart(input logic [XLEN-1:0] start);
    logic [XLEN-1:0] pc;
    exp_q.delete();
    pc = start;
    repeat (64) begin
      exp_q.push_back({pc, pc[31:0]});
      pc = pc + 64'd4;
    end
  endtask

  // Instruction memory: answers exactly one cycle after a request, word = addr.
  // inject_rv forces one response strobe with no request behind it.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_r = imem_req;
      mem_a = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = mem_r | inject_rv;
      imem_rdata  = mem_r ? mem_a[31:0] : 32'hdead_beef;
      inject_rv   = 1'b0;
    end
  end

  // Monitor: every handshake pops the expected queue.
  always @(negedge clk) begin
    logic [XLEN+31:0] e;
    if (!reset && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e[XLEN+31:32]);
        check("inst_data", 64'(inst_data), 64'(e[31:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns 2 time units into cycle 0 (first cycle after release).
  task automatic do_reset(input logic inject, input logic ready);
    @(posedge clk);
    #2;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    inst_ready     = ready;
    #1;
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_inst_pc", inst_pc, 64'd0);
    check("rst_inst_data", 64'(inst_data), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_perf_fetched", 64'(perf_fetched), 64'd0);
    check("rst_perf_flushes", 64'(perf_flushes), 64'd0);
`endif
    @(negedge clk);
    #1;
    inject_rv = inject;
    sb_restart('0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Checks the three cycles after reset release: first valid at cycle 2.
  task automatic check_restart_timing();
    @(negedge clk);
    check("c0_imem_req", 64'(imem_req), 64'd1);
    check("c0_imem_addr", imem_addr, 64'd0);
    check("c0_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    check("c1_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    check("c2_inst_valid", 64'(inst_valid), 64'd1);
    check("c2_inst_pc", inst_pc, 64'd0);
  endtask

  // Single redirect cycle; returns 2 time units into cycle T+1.
  task automatic redirect(input logic [XLEN-1:0] target);
    logic [XLEN-1:0] aligned;
    aligned = {target[XLEN-1:2], 2'b00};
    @(posedge clk);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    check("redir_imem_req", 64'(imem_req), 64'd1);
    check("redir_imem_addr", imem_addr, aligned);
    #1;
    sb_restart(aligned);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #2;
    inst_ready = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    inject_rv      = 1'b0;

    // Streaming from reset; a spurious strobe in cycle 0 must be dropped.
    do_reset(1'b1, 1'b1);
    check_restart_timing();
    repeat (6) @(negedge clk);

    // Stall 10 cycles: exactly 4 entries, request stops at count+inflight=4.
    do_reset(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("stall_c3_req", 64'(imem_req), 64'd1);
    @(negedge clk);
    check("stall_c4_req", 64'(imem_req), 64'd0);
    repeat (5) @(negedge clk);
    check("stall_c9_valid", 64'(inst_valid), 64'd1);
    check("stall_c9_req", 64'(imem_req), 64'd0);
    check("stall_c9_pc", inst_pc, 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("stall_perf_fetched", 64'(perf_fetched), 64'd4);
    check("stall_perf_flushes", 64'(perf_flushes), 64'd0);
`endif
    set_ready(1'b1);
    repeat (10) @(negedge clk);

    // Redirect with 3 entries stored and one request in flight.
    do_reset(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    redirect(64'h100);
    inst_ready = 1'b1;
    @(negedge clk);
    check("redir_t1_valid", 64'(inst_valid), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("redir_perf_flushes", 64'(perf_flushes), 64'd1);
`endif
    @(negedge clk);
    check("redir_t2_valid", 64'(inst_valid), 64'd1);
    check("redir_t2_pc", inst_pc, 64'h100);
    repeat (4) @(negedge clk);

    // Unaligned target while streaming (redirect coincides with a pop).
    redirect(64'h203);
    @(negedge clk);
    @(negedge clk);
    check("unal_t2_pc", inst_pc, 64'h200);
    repeat (4) @(negedge clk);

    // PC wrap at the top of the address space.
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    check("wrap_t1_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    @(negedge clk);
    check("wrap_t2_addr", imem_addr, 64'd0);
    repeat (6) @(negedge clk);

    // Back-to-back redirects: only the second target's stream survives.
    @(posedge clk);
    #2;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h800;
    @(posedge clk);
    #2;
    redirect_pc    = 64'hC00;
    @(negedge clk);
    check("b2b_imem_addr", imem_addr, 64'hC00);
    #1;
    sb_restart(64'hC00);
    @(posedge clk);
    #2;
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_t2_pc", inst_pc, 64'hC00);
    repeat (4) @(negedge clk);

    // Redirect while full: credit check is bypassed.
    set_ready(1'b0);
    repeat (8) @(negedge clk);
    check("full_req", 64'(imem_req), 64'd0);
    redirect(64'h400);
    inst_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Reset mid-stream with a full FIFO.
    set_ready(1'b0);
    repeat (8) @(negedge clk);
    check("full_valid", 64'(inst_valid), 64'd1);
    do_reset(1'b0, 1'b1);
    check_restart_timing();
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
